aes128_encrypt_iter: RTL and testbench

- Iterative AES-128 encryption core: one round per clock, round keys generated on the fly.
- Transmit-side counterpart to the unrolled combinational decryption datapath. Its ciphertext output feeds that decryptor directly.
- Sits between a plaintext source and the channel or decryptor, with valid/ready handshakes on both sides.

---
 rtl/aes_pkg.sv | 78 +++++++
 rtl/aes_enc_round.sv | 48 ++++
 rtl/aes128_encrypt_iter.sv | 120 ++++++++++++
 tb/tb_aes128_encrypt_iter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, S-box, round constants and GF(2^8) helpers.
// Used by the iterative encryptor and the unrolled decryptor.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic byte_t sbox(input byte_t b);
    return SBOX[b];
  endfunction

  // Rounds are numbered 1..10; anything else yields zero.
  function automatic byte_t rcon_of(input logic [3:0] rnd);
    if (rnd >= 4'd1 && rnd <= 4'd10) begin
      return RCON[rnd - 4'd1];
    end
    return 8'h00;
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round.
// i_final bypasses MixColumns for the last round.
module aes_enc_round
  import aes_pkg::*;
(
  input  block_t i_state,
  input  block_t i_rkey,
  input  logic   i_final,
  output block_t o_state
);

  byte_t w_sb [16];
  byte_t w_sr [16];
  byte_t w_mc [16];

  for (genvar i = 0; i < 16; i++) begin : g_sb
    assign w_sb[i] = sbox(i_state[127-8*i -: 8]);
  end

  // Byte 4c+r sits at row r, column c.
  for (genvar c = 0; c < 4; c++) begin : g_sr_c
    for (genvar r = 0; r < 4; r++) begin : g_sr_r
      assign w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mc
    byte_t w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_sr[4*c+0];
    assign w_a1 = w_sr[4*c+1];
    assign w_a2 = w_sr[4*c+2];
    assign w_a3 = w_sr[4*c+3];
    assign w_mc[4*c+0] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1
                       ^ w_a2 ^ w_a3;
    assign w_mc[4*c+1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2)
                       ^ w_a2 ^ w_a3;
    assign w_mc[4*c+2] = w_a0 ^ w_a1 ^ xtime(w_a2)
                       ^ xtime(w_a3) ^ w_a3;
    assign w_mc[4*c+3] = xtime(w_a0) ^ w_a0 ^ w_a1
                       ^ w_a2 ^ xtime(w_a3);
  end

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign o_state[127-8*i -: 8] =
      (i_final ? w_sr[i] : w_mc[i]) ^ i_rkey[127-8*i -: 8];
  end

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock,
// round keys expanded on the fly alongside the state.
module aes128_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  fsm_t       r_fsm;
  block_t     r_state;
  block_t     r_rkey;
  logic [3:0] r_rnd;
  block_t     r_out;
  logic       r_out_valid;

  fsm_t   w_fsm_nxt;
  logic   w_load;
  logic   w_step;
  logic   w_fin;
  logic   w_ack;
  logic   w_last;
  word_t  w_rot;
  word_t  w_k0, w_k1, w_k2, w_k3;
  block_t w_nkey;
  block_t w_round;

  assign w_last = (r_rnd == 4'(NR));

  assign w_rot = {r_rkey[23:0], r_rkey[31:24]};
  assign w_k0  = r_rkey[127:96] ^ sub_word(w_rot)
               ^ {rcon_of(r_rnd), 24'h0};
  assign w_k1  = r_rkey[95:64] ^ w_k0;
  assign w_k2  = r_rkey[63:32] ^ w_k1;
  assign w_k3  = r_rkey[31:0]  ^ w_k2;
  assign w_nkey = {w_k0, w_k1, w_k2, w_k3};

  aes_enc_round u_round (
    .i_state (r_state),
    .i_rkey  (w_nkey),
    .i_final (w_last),
    .o_state (w_round)
  );

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_fin     = 1'b0;
    w_ack     = 1'b0;
    unique case (r_fsm)
      IDLE: begin
        if (in_valid) begin
          w_load    = 1'b1;
          w_fsm_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_fin     = 1'b1;
          w_fsm_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_ack     = 1'b1;
          w_fsm_nxt = IDLE;
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_state     <= '0;
      r_rkey      <= '0;
      r_rnd       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_fsm <= w_fsm_nxt;
      if (w_load) begin
        r_state <= in_data ^ in_key;
        r_rkey  <= in_key;
        r_rnd   <= 4'd1;
      end
      if (w_step) begin
        r_state <= w_round;
        r_rkey  <= w_nkey;
        r_rnd   <= r_rnd + 4'd1;
      end
      if (w_fin) begin
        r_out       <= w_round;
        r_out_valid <= 1'b1;
      end
      if (w_ack) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_fsm == IDLE);
  assign busy      = (r_fsm == RUN);
  assign out_valid = r_out_valid;
  assign out_data  = r_out;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Self-checking bench for aes128_encrypt_iter: known vectors,
// corner sequences and random blocks against a byte-level model.
module tb_aes128_encrypt_iter;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  aes128_encrypt_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from the field inverse and the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      logic [7:0] v;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv;
      v = inv;
      for (int k = 0; k < 4; k++) begin
        v = {v[6:0], v[7]};
        s = s ^ v;
      end
      s = s ^ 8'h63;
      sb[x] = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic void expand(input logic [127:0] key,
                                 output logic [31:0] w [44]);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] key,
                                           input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   st [4][4];
    logic [7:0]   t  [4][4];
    logic [127:0] res;
    expand(key, w);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = sb[st[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rd < 10)
            st[r][c] = gm(8'h02, t[r][c]) ^ gm(8'h03, t[(r+1)%4][c])
                     ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            st[r][c] = t[r][c];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          st[r][c] = st[r][c] ^ w[4*rd+c][31-8*r -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = st[r][c];
    return res;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] key,
                                           input logic [127:0] ct);
    logic [31:0]  w [44];
    logic [7:0]   st [4][4];
    logic [7:0]   t  [4][4];
    logic [127:0] res;
    expand(key, w);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = ct[127-8*(4*c+r) -: 8] ^ w[40+c][31-8*r -: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = isb[st[r][(c-r+4)%4]] ^ w[4*rd+c][31-8*r -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rd > 0)
            st[r][c] = gm(8'h0e, t[r][c]) ^ gm(8'h0b, t[(r+1)%4][c])
                     ^ gm(8'h0d, t[(r+2)%4][c]) ^ gm(8'h09, t[(r+3)%4][c]);
          else
            st[r][c] = t[r][c];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = st[r][c];
    return res;
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Handshake one block, scramble inputs while it runs, wait for out_valid.
  task automatic run_block(input logic [127:0] key,
                           input logic [127:0] pt,
                           output logic [127:0] ct,
                           output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = pt;
    in_key   = key;
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid  = 1'($urandom);
      in_data   = rnd128();
      in_key    = rnd128();
      out_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    ct = out_data;
  endtask

  task automatic finish_out();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ack_out_valid", {127'd0, out_valid}, 128'd0);
    chk("ack_in_ready", {127'd0, in_ready}, 128'd1);
  endtask

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  initial begin
    logic [127:0] ct;
    logic [127:0] hold;
    logic [127:0] k;
    logic [127:0] p;
    int lat;
    bit bad_data;
    bit bad_v;
    bit bad_r;

    vecs[0] = '{"fips_b", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{"fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{"zero", 128'h0, 128'h0,
                128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    build_sbox();

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    in_key = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      run_block(vecs[i].key, vecs[i].pt, ct, lat);
      chk({vecs[i].name, "_ct"}, ct, vecs[i].ct);
      chk_i({vecs[i].name, "_lat"}, lat, 10);
      chk({vecs[i].name, "_loop"}, ref_dec(vecs[i].key, ct), vecs[i].pt);
      finish_out();
    end

    run_block(vecs[0].key, vecs[0].pt, ct, lat);
    chk("bp_ct", ct, vecs[0].ct);
    hold = out_data;
    bad_data = 1'b0;
    bad_v = 1'b0;
    bad_r = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom);
      in_data  = rnd128();
      in_key   = rnd128();
      @(negedge clk);
      if (out_data !== hold) bad_data = 1'b1;
      if (out_valid !== 1'b1) bad_v = 1'b1;
      if (in_ready !== 1'b0) bad_r = 1'b1;
    end
    chk("bp_data_stable", {127'd0, bad_data}, 128'd0);
    chk("bp_valid_held", {127'd0, bad_v}, 128'd0);
    chk("bp_in_ready_low", {127'd0, bad_r}, 128'd0);
    finish_out();
    run_block(vecs[1].key, vecs[1].pt, ct, lat);
    chk("bp_next_ct", ct, vecs[1].ct);
    chk_i("bp_next_lat", lat, 10);
    finish_out();

    @(negedge clk);
    in_valid = 1'b1;
    in_data  = vecs[0].pt;
    in_key   = vecs[0].key;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_busy", {127'd0, busy}, 128'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("abort_out_valid", {127'd0, out_valid}, 128'd0);
    chk("abort_out_data", out_data, 128'd0);
    chk("abort_in_ready", {127'd0, in_ready}, 128'd1);
    chk("abort_busy", {127'd0, busy}, 128'd0);
    run_block(vecs[1].key, vecs[1].pt, ct, lat);
    chk("abort_next_ct", ct, vecs[1].ct);
    finish_out();

    for (int i = 0; i < 100; i++) begin
      k = rnd128();
      p = rnd128();
      run_block(k, p, ct, lat);
      chk("rand_ct", ct, ref_enc(k, p));
      chk_i("rand_lat", lat, 10);
      chk("rand_loop", ref_dec(k, ct), p);
      finish_out();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
